// File: rtl/calc_share_arbiter_if.sv
// Requester, response and engine-side signals of the shared calculation engine arbiter.
// master = client/engine environment, slave = arbiter.
interface calc_share_arbiter_if #(
    parameter int NUM_OPS = 4
);
    logic                   a_req_valid;
    logic                   a_req_ready;
    logic [1:0]             a_mode;
    logic [NUM_OPS*4-1:0]   a_ops;

    logic                   b_req_valid;
    logic                   b_req_ready;
    logic [1:0]             b_mode;
    logic [NUM_OPS*4-1:0]   b_ops;

    logic                   eng_in_valid;
    logic [3:0]             eng_in_number;
    logic [1:0]             eng_mode;
    logic                   eng_out_valid;
    logic signed [5:0]      eng_out_result;

    logic                   a_rsp_valid;
    logic                   b_rsp_valid;
    logic signed [5:0]      rsp_result;
    logic                   rsp_timeout;
    logic                   busy;

    modport master (
        output a_req_valid, a_mode, a_ops,
        output b_req_valid, b_mode, b_ops,
        output eng_out_valid, eng_out_result,
        input  a_req_ready, b_req_ready,
        input  eng_in_valid, eng_in_number, eng_mode,
        input  a_rsp_valid, b_rsp_valid,
        input  rsp_result, rsp_timeout, busy
    );

    modport slave (
        input  a_req_valid, a_mode, a_ops,
        input  b_req_valid, b_mode, b_ops,
        input  eng_out_valid, eng_out_result,
        output a_req_ready, b_req_ready,
        output eng_in_valid, eng_in_number, eng_mode,
        output a_rsp_valid, b_rsp_valid,
        output rsp_result, rsp_timeout, busy
    );
endinterface

// File: rtl/calc_share_arbiter.sv
// Round-robin share of one serial calculation engine between requesters A and B:
// grant, stream operands one nibble per cycle, wait (with timeout), return result.
module calc_share_arbiter #(
    parameter int NUM_OPS = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    calc_share_arbiter_if.slave  bus
);
    localparam int OPS_W = NUM_OPS * 4;
    localparam logic [CNT_W-1:0] LAST_OP   = CNT_W'(NUM_OPS - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [OPS_W-1:0]  ops_q;
    logic              last_b;
    logic              owner_b;

    logic              in_valid_q;
    logic [3:0]        in_number_q;
    logic [1:0]        mode_q;
    logic              a_rsp_q;
    logic              b_rsp_q;
    logic signed [5:0] result_q;
    logic              timeout_q;

    logic              grant_a;
    logic              grant_b;
    logic [OPS_W-1:0]  sel_ops;
    logic [1:0]        sel_mode;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE) begin
            unique case (1'b1)
                bus.a_req_valid && bus.b_req_valid: begin
                    grant_a = last_b;
                    grant_b = !last_b;
                end
                bus.a_req_valid && !bus.b_req_valid: grant_a = 1'b1;
                !bus.a_req_valid && bus.b_req_valid: grant_b = 1'b1;
                default: ;
            endcase
        end
    end

    assign sel_ops  = grant_b ? bus.b_ops : bus.a_ops;
    assign sel_mode = grant_b ? bus.b_mode : bus.a_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ops_q       <= '0;
            last_b      <= 1'b1;
            owner_b     <= 1'b0;
            in_valid_q  <= 1'b0;
            in_number_q <= '0;
            mode_q      <= '0;
            a_rsp_q     <= 1'b0;
            b_rsp_q     <= 1'b0;
            result_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            a_rsp_q <= 1'b0;
            b_rsp_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        owner_b     <= grant_b;
                        last_b      <= grant_b;
                        in_valid_q  <= 1'b1;
                        in_number_q <= sel_ops[3:0];
                        ops_q       <= sel_ops >> 4;
                        mode_q      <= sel_mode;
                        cnt         <= '0;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (cnt == LAST_OP) begin
                        in_valid_q  <= 1'b0;
                        in_number_q <= '0;
                        mode_q      <= '0;
                        cnt         <= '0;
                        state       <= WAIT;
                    end else begin
                        in_number_q <= ops_q[3:0];
                        ops_q       <= ops_q >> 4;
                        cnt         <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    // A result arriving on the last allowed cycle still wins.
                    if (bus.eng_out_valid) begin
                        result_q  <= bus.eng_out_result;
                        timeout_q <= 1'b0;
                        a_rsp_q   <= !owner_b;
                        b_rsp_q   <= owner_b;
                        state     <= RESP;
                    end else if (cnt == LAST_WAIT) begin
                        result_q  <= '0;
                        timeout_q <= 1'b1;
                        a_rsp_q   <= !owner_b;
                        b_rsp_q   <= owner_b;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_req_ready   = grant_a;
    assign bus.b_req_ready   = grant_b;
    assign bus.eng_in_valid  = in_valid_q;
    assign bus.eng_in_number = in_number_q;
    assign bus.eng_mode      = mode_q;
    assign bus.a_rsp_valid   = a_rsp_q;
    assign bus.b_rsp_valid   = b_rsp_q;
    assign bus.rsp_result    = result_q;
    assign bus.rsp_timeout   = timeout_q;
    assign bus.busy          = (state != IDLE);
endmodule
